// File: rtl/dmem_access_unit.sv
// -----------------------------------------------------------------------------
// dmem_access_unit
//   Load/store initiator sitting between the MEM pipeline stage and the data
//   memory. It accepts one access at a time, drives a level req/valid
//   handshake towards memory, stalls the pipeline while the access is in
//   flight and returns sign/zero-extended load data. Byte and halfword stores
//   are done as a read-modify-write of the containing word. Misaligned or
//   unsupported accesses complete without touching memory, and an 8-bit
//   watchdog abandons a request that memory never answers.
//
// Ports
//   clk, reset            rising-edge clock, asynchronous active-low reset
//   lsu_start             access request, sampled only in IDLE or RESP
//   lsu_load/lsu_store    access kind (store wins if both are set)
//   lsu_funct3            000 B, 001 H, 010 W, 100 BU, 101 HU
//   lsu_addr/lsu_wdata    byte address (bits 31:12 ignored), right-aligned data
//   lsu_busy              pipeline stall while the access is outstanding
//   lsu_done              one-cycle completion pulse
//   lsu_rdata             extended load result, valid with lsu_done, else 0
//   lsu_misaligned        with lsu_done: access rejected, memory untouched
//   lsu_timeout           with lsu_done: memory did not answer in time
//   mem_read_req/_write_req  level requests, at most one high at a time
//   mem_addr/mem_write_data  word address and full word to write
//   mem_read_data/mem_read_valid/mem_write_back_valid  memory responses
// -----------------------------------------------------------------------------
module dmem_access_unit #(
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        lsu_start,
  input  logic        lsu_load,
  input  logic        lsu_store,
  input  logic [2:0]  lsu_funct3,
  input  logic [31:0] lsu_addr,
  input  logic [31:0] lsu_wdata,
  output logic        lsu_busy,
  output logic        lsu_done,
  output logic [31:0] lsu_rdata,
  output logic        lsu_misaligned,
  output logic        lsu_timeout,
  output logic        mem_read_req,
  output logic        mem_write_req,
  output logic [11:0] mem_addr,
  output logic [31:0] mem_write_data,
  input  logic [31:0] mem_read_data,
  input  logic        mem_read_valid,
  input  logic        mem_write_back_valid
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_RD,
    S_RMW_RD,
    S_RMW_GAP,
    S_STORE_WR,
    S_RESP
  } state_t;

  localparam logic [7:0] TO_LIMIT = 8'(TIMEOUT_CYCLES);

  state_t      state_q;
  logic [2:0]  funct3_q;
  logic [11:0] addr_q;
  logic [15:0] wdata_q;
  logic [7:0]  wd_cnt_q;

  logic        busy_q;
  logic        done_q;
  logic [31:0] rdata_q;
  logic        misaligned_q;
  logic        timeout_q;
  logic        rd_req_q;
  logic        wr_req_q;
  logic [11:0] mem_addr_q;
  logic [31:0] mem_wdata_q;

  // Address bits above the 4 KiB window are intentionally dropped.
  logic unused_addr_bits;
  assign unused_addr_bits = ^lsu_addr[31:12];

  // ---------------------------------------------------------------------------
  // Acceptance decode (only meaningful in IDLE/RESP)
  // ---------------------------------------------------------------------------
  logic can_accept;
  logic accept;
  logic f3_legal;
  logic misaligned;
  logic access_bad;

  assign can_accept = (state_q == S_IDLE) || (state_q == S_RESP);
  assign accept     = can_accept && lsu_start && (lsu_load || lsu_store);

  always_comb begin
    f3_legal = 1'b0;
    case (lsu_funct3)
      3'b000, 3'b001, 3'b010: f3_legal = 1'b1;
      3'b100, 3'b101:         f3_legal = !lsu_store;  // unsigned forms are load-only
      default:                f3_legal = 1'b0;
    endcase
  end

  // funct3[1:0]==01 covers both H and HU.
  assign misaligned = ((lsu_funct3[1:0] == 2'b01) && lsu_addr[0]) ||
                      ((lsu_funct3 == 3'b010) && (lsu_addr[1:0] != 2'b00));
  assign access_bad = !f3_legal || misaligned;

  // ---------------------------------------------------------------------------
  // Load lane extraction and extension
  // ---------------------------------------------------------------------------
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] load_ext;

  always_comb begin
    ld_byte = mem_read_data[7:0];
    case (addr_q[1:0])
      2'd0:    ld_byte = mem_read_data[7:0];
      2'd1:    ld_byte = mem_read_data[15:8];
      2'd2:    ld_byte = mem_read_data[23:16];
      default: ld_byte = mem_read_data[31:24];
    endcase
    ld_half = addr_q[1] ? mem_read_data[31:16] : mem_read_data[15:0];

    load_ext = mem_read_data;
    case (funct3_q)
      3'b000:  load_ext = {{24{ld_byte[7]}}, ld_byte};
      3'b100:  load_ext = {24'd0, ld_byte};
      3'b001:  load_ext = {{16{ld_half[15]}}, ld_half};
      3'b101:  load_ext = {16'd0, ld_half};
      default: load_ext = mem_read_data;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Read-modify-write merge: each byte lane takes either store data or the
  // old memory byte. For SH the upper lane of the pair takes wdata[15:8].
  // ---------------------------------------------------------------------------
  logic [3:0]  lane_sel;
  logic [31:0] merged_word;

  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    localparam logic [1:0] LANE = 2'(gi);
    assign lane_sel[gi] = funct3_q[0] ? (addr_q[1] == LANE[1]) : (addr_q[1:0] == LANE);
    assign merged_word[gi*8 +: 8] = !lane_sel[gi]          ? mem_read_data[gi*8 +: 8] :
                                    (LANE[0] && funct3_q[0]) ? wdata_q[15:8] : wdata_q[7:0];
  end

  // Watchdog fires on the TIMEOUT_CYCLES-th cycle a request has been high.
  logic wd_expired;
  assign wd_expired = (wd_cnt_q + 8'd1) == TO_LIMIT;

  // ---------------------------------------------------------------------------
  // FSM with registered outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      funct3_q     <= 3'd0;
      addr_q       <= 12'd0;
      wdata_q      <= 16'd0;
      wd_cnt_q     <= 8'd0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      rdata_q      <= 32'd0;
      misaligned_q <= 1'b0;
      timeout_q    <= 1'b0;
      rd_req_q     <= 1'b0;
      wr_req_q     <= 1'b0;
      mem_addr_q   <= 12'd0;
      mem_wdata_q  <= 32'd0;
    end else begin
      case (state_q)
        S_IDLE, S_RESP: begin
          // Completion flags and data live for exactly one RESP cycle.
          state_q      <= S_IDLE;
          done_q       <= 1'b0;
          misaligned_q <= 1'b0;
          timeout_q    <= 1'b0;
          rdata_q      <= 32'd0;
          if (accept) begin
            funct3_q   <= lsu_funct3;
            addr_q     <= lsu_addr[11:0];
            wdata_q    <= lsu_wdata[15:0];
            mem_addr_q <= {lsu_addr[11:2], 2'b00};
            wd_cnt_q   <= 8'd0;
            if (access_bad) begin
              state_q      <= S_RESP;
              done_q       <= 1'b1;
              misaligned_q <= 1'b1;
            end else if (!lsu_store) begin
              state_q  <= S_LOAD_RD;
              rd_req_q <= 1'b1;
              busy_q   <= 1'b1;
            end else if (lsu_funct3 == 3'b010) begin
              state_q     <= S_STORE_WR;
              wr_req_q    <= 1'b1;
              mem_wdata_q <= lsu_wdata;
              busy_q      <= 1'b1;
            end else begin
              state_q  <= S_RMW_RD;
              rd_req_q <= 1'b1;
              busy_q   <= 1'b1;
            end
          end
        end

        S_LOAD_RD: begin
          if (mem_read_valid) begin
            rd_req_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
            rdata_q  <= load_ext;
            state_q  <= S_RESP;
          end else if (wd_expired) begin
            rd_req_q  <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b1;
            timeout_q <= 1'b1;
            rdata_q   <= 32'd0;
            state_q   <= S_RESP;
          end else begin
            wd_cnt_q <= wd_cnt_q + 8'd1;
          end
        end

        S_RMW_RD: begin
          if (mem_read_valid) begin
            rd_req_q    <= 1'b0;
            mem_wdata_q <= merged_word;
            state_q     <= S_RMW_GAP;
          end else if (wd_expired) begin
            rd_req_q  <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b1;
            timeout_q <= 1'b1;
            state_q   <= S_RESP;
          end else begin
            wd_cnt_q <= wd_cnt_q + 8'd1;
          end
        end

        // One quiet cycle so memory sees the read request drop before the write.
        S_RMW_GAP: begin
          wr_req_q <= 1'b1;
          wd_cnt_q <= 8'd0;
          state_q  <= S_STORE_WR;
        end

        S_STORE_WR: begin
          if (mem_write_back_valid) begin
            wr_req_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
            state_q  <= S_RESP;
          end else if (wd_expired) begin
            wr_req_q  <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b1;
            timeout_q <= 1'b1;
            state_q   <= S_RESP;
          end else begin
            wd_cnt_q <= wd_cnt_q + 8'd1;
          end
        end

        default: begin
          state_q  <= S_IDLE;
          rd_req_q <= 1'b0;
          wr_req_q <= 1'b0;
          busy_q   <= 1'b0;
          done_q   <= 1'b0;
        end
      endcase
    end
  end

  assign lsu_busy       = busy_q;
  assign lsu_done       = done_q;
  assign lsu_rdata      = rdata_q;
  assign lsu_misaligned = misaligned_q;
  assign lsu_timeout    = timeout_q;
  assign mem_read_req   = rd_req_q;
  assign mem_write_req  = wr_req_q;
  assign mem_addr       = mem_addr_q;
  assign mem_write_data = mem_wdata_q;

endmodule

// File: tb/tb_dmem_access_unit.sv
// -----------------------------------------------------------------------------
// tb_dmem_access_unit
//   Directed bench for dmem_access_unit with a small behavioural data memory
//   (programmable latency, can be muted to never answer). Expected values are
//   hand-computed constants.
// -----------------------------------------------------------------------------
module tb_dmem_access_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        lsu_start = 1'b0;
  logic        lsu_load = 1'b0;
  logic        lsu_store = 1'b0;
  logic [2:0]  lsu_funct3 = 3'd0;
  logic [31:0] lsu_addr = 32'd0;
  logic [31:0] lsu_wdata = 32'd0;
  logic        lsu_busy;
  logic        lsu_done;
  logic [31:0] lsu_rdata;
  logic        lsu_misaligned;
  logic        lsu_timeout;
  logic        mem_read_req;
  logic        mem_write_req;
  logic [11:0] mem_addr;
  logic [31:0] mem_write_data;
  logic [31:0] mem_read_data;
  logic        mem_read_valid;
  logic        mem_write_back_valid;

  dmem_access_unit #(.TIMEOUT_CYCLES(8)) dut (
    .clk                  (clk),
    .reset                (reset),
    .lsu_start            (lsu_start),
    .lsu_load             (lsu_load),
    .lsu_store            (lsu_store),
    .lsu_funct3           (lsu_funct3),
    .lsu_addr             (lsu_addr),
    .lsu_wdata            (lsu_wdata),
    .lsu_busy             (lsu_busy),
    .lsu_done             (lsu_done),
    .lsu_rdata            (lsu_rdata),
    .lsu_misaligned       (lsu_misaligned),
    .lsu_timeout          (lsu_timeout),
    .mem_read_req         (mem_read_req),
    .mem_write_req        (mem_write_req),
    .mem_addr             (mem_addr),
    .mem_write_data       (mem_write_data),
    .mem_read_data        (mem_read_data),
    .mem_read_valid       (mem_read_valid),
    .mem_write_back_valid (mem_write_back_valid)
  );

  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Memory model: valid pulses after the request has been seen high for
  // 'lat' edges; the counter restarts whenever requests are low.
  // ---------------------------------------------------------------------------
  logic [31:0] mem [0:1023];
  int          lat = 2;
  logic        mute = 1'b0;
  int          m_cnt;
  logic        pl_we = 1'b0;
  logic [9:0]  pl_idx = 10'd0;
  logic [31:0] pl_data = 32'd0;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_cnt                <= 0;
      mem_read_valid       <= 1'b0;
      mem_write_back_valid <= 1'b0;
      mem_read_data        <= 32'd0;
    end else begin
      mem_read_valid       <= 1'b0;
      mem_write_back_valid <= 1'b0;
      if (pl_we) mem[pl_idx] <= pl_data;
      if (mem_read_valid || mem_write_back_valid) begin
        m_cnt <= 0;
      end else if ((mem_read_req || mem_write_req) && !mute) begin
        if (m_cnt + 1 == lat) begin
          m_cnt <= 0;
          if (mem_read_req) begin
            mem_read_valid <= 1'b1;
            mem_read_data  <= mem[mem_addr[11:2]];
          end else begin
            mem_write_back_valid <= 1'b1;
            mem[mem_addr[11:2]]  <= mem_write_data;
          end
        end else begin
          m_cnt <= m_cnt + 1;
        end
      end else begin
        m_cnt <= 0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Checking helpers
  // ---------------------------------------------------------------------------
  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $display("FAIL %s: observed %h, expected %h", tag, obs, exp);
      $error("%s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic poke(input logic [9:0] idx, input logic [31:0] data);
    pl_we   = 1'b1;
    pl_idx  = idx;
    pl_data = data;
    tick();
    pl_we   = 1'b0;
  endtask

  int          op_cyc, op_rq, op_wq, op_busy, op_gap, op_dual;
  logic [31:0] op_rdata;
  logic        op_mis, op_to;

  // Drives one access (accepted at the next edge) and follows it to lsu_done.
  task automatic run_op(input string name, input logic ld, input logic st,
                        input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wd);
    lsu_start  = 1'b1;
    lsu_load   = ld;
    lsu_store  = st;
    lsu_funct3 = f3;
    lsu_addr   = addr;
    lsu_wdata  = wd;
    op_cyc = 0; op_rq = 0; op_wq = 0; op_busy = 0; op_gap = 0; op_dual = 0;
    do begin
      tick();
      lsu_start = 1'b0;
      lsu_load  = 1'b0;
      lsu_store = 1'b0;
      op_cyc++;
      if (mem_read_req) op_rq++;
      if (mem_write_req) op_wq++;
      if (lsu_busy) op_busy++;
      if (lsu_busy && !mem_read_req && !mem_write_req) op_gap++;
      if (mem_read_req && mem_write_req) op_dual++;
    end while (!lsu_done && op_cyc < 60);
    op_rdata = lsu_rdata;
    op_mis   = lsu_misaligned;
    op_to    = lsu_timeout;
    $display("op %-10s addr=%03h cyc=%0d rreq=%0d wreq=%0d rdata=%h mis=%0b to=%0b",
             name, addr[11:0], op_cyc, op_rq, op_wq, op_rdata, op_mis, op_to);
    chk({name, " done_seen"}, 32'(lsu_done), 32'd1);
    chk({name, " done_busy"}, 32'(lsu_busy), 32'd0);
  endtask

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------
  initial begin
    // Reset state
    tick();
    tick();
    chk("rst busy", 32'(lsu_busy), 32'd0);
    chk("rst done", 32'(lsu_done), 32'd0);
    chk("rst rdata", lsu_rdata, 32'd0);
    chk("rst reqs", 32'({mem_read_req, mem_write_req}), 32'd0);
    chk("rst addr", 32'(mem_addr), 32'd0);
    chk("rst wdata", mem_write_data, 32'd0);
    reset = 1'b1;
    tick();

    // 1: LW with latency 2
    poke(10'd0, 32'hDEADBEEF);
    poke(10'd1, 32'h12345678);
    poke(10'd2, 32'h11223344);
    run_op("LW_004", 1'b1, 1'b0, 3'b010, 32'h0000_0004, 32'd0);
    chk("lw cyc", 32'(op_cyc), 32'd4);
    chk("lw rreq_cycles", 32'(op_rq), 32'd3);
    chk("lw busy_cycles", 32'(op_busy), 32'd3);
    chk("lw rdata", op_rdata, 32'h12345678);
    chk("lw flags", 32'({op_mis, op_to}), 32'd0);
    chk("lw mem_addr", 32'(mem_addr), 32'h004);
    tick();
    chk("resp exit done", 32'(lsu_done), 32'd0);
    chk("resp exit rdata", lsu_rdata, 32'd0);

    // 2: sub-word loads, upper address bits ignored
    poke(10'd1, 32'h80FF0011);
    run_op("LB_007", 1'b1, 1'b0, 3'b000, 32'hFFFF_F007, 32'd0);
    chk("lb rdata", op_rdata, 32'hFFFFFF80);
    chk("lb mem_addr", 32'(mem_addr), 32'h004);
    run_op("LBU_007", 1'b1, 1'b0, 3'b100, 32'h0000_0007, 32'd0);
    chk("lbu rdata", op_rdata, 32'h00000080);
    run_op("LH_004", 1'b1, 1'b0, 3'b001, 32'h0000_0004, 32'd0);
    chk("lh4 rdata", op_rdata, 32'h00000011);
    run_op("LH_006", 1'b1, 1'b0, 3'b001, 32'h0000_0006, 32'd0);
    chk("lh6 rdata", op_rdata, 32'hFFFF80FF);
    run_op("LHU_006", 1'b1, 1'b0, 3'b101, 32'h0000_0006, 32'd0);
    chk("lhu6 rdata", op_rdata, 32'h000080FF);
    run_op("LB_006", 1'b1, 1'b0, 3'b000, 32'h0000_0006, 32'd0);
    chk("lb6 rdata", op_rdata, 32'hFFFFFFFF);

    // 3: read-modify-write stores and a plain SW
    run_op("SB_00A", 1'b0, 1'b1, 3'b000, 32'h0000_000A, 32'h000000AB);
    chk("sb cyc", 32'(op_cyc), 32'd8);
    chk("sb rreq_cycles", 32'(op_rq), 32'd3);
    chk("sb wreq_cycles", 32'(op_wq), 32'd3);
    chk("sb gap_cycles", 32'(op_gap), 32'd1);
    chk("sb dual_req", 32'(op_dual), 32'd0);
    chk("sb rdata", op_rdata, 32'd0);
    chk("sb mem", mem[2], 32'h11AB3344);
    chk("sb wdata_port", mem_write_data, 32'h11AB3344);
    run_op("SH_002", 1'b0, 1'b1, 3'b001, 32'h0000_0002, 32'h1234CAFE);
    chk("sh mem", mem[0], 32'hCAFEBEEF);
    run_op("SH_000", 1'b0, 1'b1, 3'b001, 32'h0000_0000, 32'h00005566);
    chk("sh0 mem", mem[0], 32'hCAFE5566);
    run_op("SB_001", 1'b0, 1'b1, 3'b000, 32'h0000_0001, 32'hFFFFFF77);
    chk("sb1 mem", mem[0], 32'hCAFE7766);
    run_op("SW_008", 1'b0, 1'b1, 3'b010, 32'h0000_0008, 32'h5A5A5A5A);
    chk("sw cyc", 32'(op_cyc), 32'd4);
    chk("sw rreq_cycles", 32'(op_rq), 32'd0);
    chk("sw mem", mem[2], 32'h5A5A5A5A);
    run_op("LW_008", 1'b1, 1'b1 & 1'b0, 3'b010, 32'h0000_0008, 32'd0);
    chk("lw8 rdata", op_rdata, 32'h5A5A5A5A);

    // 4: misaligned / unsupported accesses never reach memory
    run_op("LW_006", 1'b1, 1'b0, 3'b010, 32'h0000_0006, 32'd0);
    chk("lw6 cyc", 32'(op_cyc), 32'd1);
    chk("lw6 mis", 32'(op_mis), 32'd1);
    chk("lw6 reqs", 32'(op_rq + op_wq), 32'd0);
    chk("lw6 rdata", op_rdata, 32'd0);
    run_op("SH_003", 1'b0, 1'b1, 3'b001, 32'h0000_0003, 32'h0000FFFF);
    chk("sh3 cyc", 32'(op_cyc), 32'd1);
    chk("sh3 mis", 32'(op_mis), 32'd1);
    chk("sh3 reqs", 32'(op_rq + op_wq), 32'd0);
    run_op("SBU_000", 1'b0, 1'b1, 3'b100, 32'h0000_0000, 32'h000000EE);
    chk("sbu mis", 32'(op_mis), 32'd1);
    run_op("LX_000", 1'b1, 1'b0, 3'b011, 32'h0000_0000, 32'd0);
    chk("f3_011 mis", 32'(op_mis), 32'd1);
    chk("mis mem0", mem[0], 32'hCAFE7766);
    tick();
    chk("mis exit flag", 32'(lsu_misaligned), 32'd0);

    // 5: watchdog boundary (valid in the expiry cycle wins) and real timeout
    lat = 7;
    run_op("LW_lat7", 1'b1, 1'b0, 3'b010, 32'h0000_0004, 32'd0);
    chk("lat7 cyc", 32'(op_cyc), 32'd9);
    chk("lat7 timeout", 32'(op_to), 32'd0);
    chk("lat7 rdata", op_rdata, 32'h80FF0011);
    mute = 1'b1;
    run_op("LW_mute", 1'b1, 1'b0, 3'b010, 32'h0000_0004, 32'd0);
    chk("to cyc", 32'(op_cyc), 32'd9);
    chk("to rreq_cycles", 32'(op_rq), 32'd8);
    chk("to timeout", 32'(op_to), 32'd1);
    chk("to rdata", op_rdata, 32'd0);
    run_op("SW_mute", 1'b0, 1'b1, 3'b010, 32'h0000_000C, 32'h0BADF00D);
    chk("to sw wreq_cycles", 32'(op_wq), 32'd8);
    chk("to sw timeout", 32'(op_to), 32'd1);
    tick();
    chk("to exit flag", 32'(lsu_timeout), 32'd0);
    mute = 1'b0;

    // 6: asynchronous reset in the middle of a write
    lat = 5;
    lsu_start  = 1'b1;
    lsu_store  = 1'b1;
    lsu_funct3 = 3'b010;
    lsu_addr   = 32'h0000_000C;
    lsu_wdata  = 32'h00000077;
    tick();
    lsu_start = 1'b0;
    lsu_store = 1'b0;
    tick();
    chk("pre_rst wreq", 32'(mem_write_req), 32'd1);
    reset = 1'b0;
    #1;
    chk("async rst wreq", 32'(mem_write_req), 32'd0);
    chk("async rst busy", 32'(lsu_busy), 32'd0);
    chk("async rst addr", 32'(mem_addr), 32'd0);
    chk("async rst wdata", mem_write_data, 32'd0);
    tick();
    reset = 1'b1;
    tick();
    lat = 2;
    run_op("LW_b2b_a", 1'b1, 1'b0, 3'b010, 32'h0000_0004, 32'd0);
    chk("b2b a rdata", op_rdata, 32'h80FF0011);
    run_op("LW_b2b_b", 1'b1, 1'b0, 3'b010, 32'h0000_0008, 32'd0);
    chk("b2b b cyc", 32'(op_cyc), 32'd4);
    chk("b2b b rdata", op_rdata, 32'h5A5A5A5A);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
